// File: rtl/bsg_periodic_pkg.sv
// Shared constants and helpers for the periodic 1:N clock-crossing endpoints.
package bsg_periodic_pkg;

    localparam int unsigned stall_cnt_w_gp = 16;

    // Phase counter width: clog2(ratio), never narrower than one bit.
    function automatic int unsigned phase_w(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/bsg_periodic_phase_counter.sv
// Fast-clock phase counter; slot_o marks the last fast cycle of every slow period.
module bsg_periodic_phase_counter
    import bsg_periodic_pkg::*;
#(
    parameter int unsigned ratio_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic slot_o
);

    localparam int unsigned cnt_w = phase_w(ratio_p);
    localparam logic [cnt_w-1:0] last_lp = cnt_w'(ratio_p - 1);

    logic [cnt_w-1:0] cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (cnt_r == last_lp) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + cnt_w'(1);
        end
    end

    // Gated by reset so ratio_p==1 does not report a slot while held in reset.
    assign slot_o = reset_n_i & (cnt_r == last_lp);

endmodule

// File: rtl/bsg_periodic_slot_buffer.sv
// Fast-side endpoint of a periodic 1:N crossing: FIFO plus a stage reloaded once per slot.
// Optional stall counter output enabled by BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN.
module bsg_periodic_slot_buffer
    import bsg_periodic_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned ratio_p = 4,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_and_o,
    output logic               slot_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_and_i
`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
    ,
    output logic [stall_cnt_w_gp-1:0] stall_cnt_o
`endif
);

    localparam int unsigned ptr_w = $clog2(els_p);

    logic [width_p-1:0] mem_r [els_p];
    logic [ptr_w:0]     wptr_r;
    logic [ptr_w:0]     rptr_r;
    logic               fifo_empty;
    logic               fifo_full;
    logic               enq;
    logic               load;
    logic               xfer;
    logic               stage_v_r;
    logic [width_p-1:0] stage_data_r;

    bsg_periodic_phase_counter #(
        .ratio_p (ratio_p)
    ) phase (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .slot_o    (slot_o)
    );

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign fifo_empty = (wptr_r == rptr_r);
    assign fifo_full  = (wptr_r[ptr_w] != rptr_r[ptr_w])
                      && (wptr_r[ptr_w-1:0] == rptr_r[ptr_w-1:0]);

    assign ready_and_o = reset_n_i & ~fifo_full;
    assign enq         = v_i & ready_and_o;
    assign xfer        = slot_o & stage_v_r & ready_and_i;
    assign load        = slot_o & (~stage_v_r | xfer) & ~fifo_empty;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r[ptr_w-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (enq)  wptr_r <= wptr_r + (ptr_w+1)'(1);
            if (load) rptr_r <= rptr_r + (ptr_w+1)'(1);
        end
    end

    // Stage only changes at the edge closing a slot, so data_o holds a full period.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage_v_r    <= 1'b0;
            stage_data_r <= '0;
        end else if (load) begin
            stage_v_r    <= 1'b1;
            stage_data_r <= mem_r[rptr_r[ptr_w-1:0]];
        end else if (xfer) begin
            stage_v_r    <= 1'b0;
        end
    end

    assign v_o    = slot_o & stage_v_r;
    assign data_o = stage_data_r;

`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
    logic [stall_cnt_w_gp-1:0] stall_cnt_r;

    // Saturating count of slots where the stage was offered but refused.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_r <= '0;
        end else if (slot_o && stage_v_r && !ready_and_i && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + stall_cnt_w_gp'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_periodic_slot_buffer.sv
// Bench for bsg_periodic_slot_buffer: ratio 4 and ratio 1 instances against a queue-level model.
module tb_bsg_periodic_slot_buffer;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic       v_i;
    logic [7:0] data_i;
    logic       ready_and_i;

    logic       rdy4, slot4, v4;
    logic [7:0] data4;
    logic       rdy1, slot1, v1;
    logic [7:0] data1;
`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
    logic [15:0] stall4, stall1;
`endif

    always #5 clk = ~clk;

    bsg_periodic_slot_buffer #(.width_p(8), .ratio_p(4), .els_p(2)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_and_o(rdy4), .slot_o(slot4), .v_o(v4), .data_o(data4),
        .ready_and_i(ready_and_i)
`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
        , .stall_cnt_o(stall4)
`endif
    );

    bsg_periodic_slot_buffer #(.width_p(8), .ratio_p(1), .els_p(2)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_and_o(rdy1), .slot_o(slot1), .v_o(v1), .data_o(data1),
        .ready_and_i(ready_and_i)
`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
        , .stall_cnt_o(stall1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    int first_out1;

    // Reference model state, index 0 = ratio 4, index 1 = ratio 1
    bit         rel;
    int         ph [2];
    bit         sv [2];
    logic [7:0] sd [2];
    logic [7:0] mq [2][2];
    int         mh [2];
    int         mc [2];
    int         st [2];
    bit         acc [2];

    logic       s_rdy4, s_slot4, s_v4;
    logic [7:0] s_data4;
    logic [7:0] out4 [$];
    logic [7:0] out1 [$];

    function automatic int rat(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; sv[k] = 1'b0; sd[k] = 8'h00;
            mh[k] = 0; mc[k] = 0; st[k] = 0; acc[k] = 1'b0;
        end
    endtask

    // One fast cycle: drive, check at negedge, advance model at posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bit se [2];
        bit re [2];
        bit ve [2];
        bit xf, ld;
        v_i = v; data_i = d; ready_and_i = r;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            se[k]  = rel && (ph[k] == rat(k) - 1);
            re[k]  = rel && (mc[k] < 2);
            ve[k]  = se[k] && sv[k];
            acc[k] = v && re[k];
        end
        s_rdy4 = rdy4; s_slot4 = slot4; s_v4 = v4; s_data4 = data4;
        chk("slot4", 32'(slot4), 32'(se[0]));
        chk("ready4", 32'(rdy4), 32'(re[0]));
        chk("v4", 32'(v4), 32'(ve[0]));
        chk("data4", 32'(data4), 32'(sd[0]));
        chk("slot1", 32'(slot1), 32'(se[1]));
        chk("ready1", 32'(rdy1), 32'(re[1]));
        chk("v1", 32'(v1), 32'(ve[1]));
        chk("data1", 32'(data1), 32'(sd[1]));
`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
        chk("stall4", 32'(stall4), 32'(st[0]));
        chk("stall1", 32'(stall1), 32'(st[1]));
`endif
        if (v4 === 1'b1) out4.push_back(data4);
        if (v1 === 1'b1) begin
            if (out1.size() == 0) first_out1 = cyc;
            out1.push_back(data1);
        end
        @(posedge clk);
        if (rel) begin
            for (int k = 0; k < 2; k++) begin
                xf = se[k] && sv[k] && r;
                ld = se[k] && (!sv[k] || xf) && (mc[k] > 0);
                if (se[k] && sv[k] && !r && st[k] < 65535) st[k]++;
                if (ld) begin
                    sd[k] = mq[k][mh[k]];
                    mh[k] = (mh[k] + 1) % 2;
                    mc[k]--;
                    sv[k] = 1'b1;
                end else if (xf) begin
                    sv[k] = 1'b0;
                end
                if (acc[k]) begin
                    mq[k][(mh[k] + mc[k]) % 2] = d;
                    mc[k]++;
                end
                ph[k] = (ph[k] + 1) % rat(k);
            end
        end
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stalls;
        int e0;
        reset_n_i = 1'b0; v_i = 1'b1; data_i = 8'h5A; ready_and_i = 1'b1;
        rel = 1'b0; cyc = 0; first_out1 = -1;
        model_reset();
        @(posedge clk); #1;

        // Reset hold with producer pushing
        repeat (3) step(1'b1, 8'h5A, 1'b1);
        reset_n_i = 1'b1; rel = 1'b1; cyc = 0;

        // Single item, first slot at cycle 3, output at cycle 7
        for (int c = 0; c < 12; c++) begin
            step(1'(c == 1), (c == 1) ? 8'hA5 : 8'h00, 1'b1);
            if (c == 3) chk("first_slot", 32'(s_slot4), 32'd1);
            if (c == 7) begin
                chk("single_v", 32'(s_v4), 32'd1);
                chk("single_data", 32'(s_data4), 32'hA5);
            end
            if (c == 11) chk("single_gone", 32'(s_v4), 32'd0);
        end

        // Burst 01..04
        out4.delete();
        for (int i = 1; i <= 4; i++) begin
            n = 0;
            do begin
                step(1'b1, 8'(i), 1'b1);
                if (i == 3 && n == 0) chk("burst_full", 32'(s_rdy4), 32'd0);
                n++;
            end while (!acc[0] && n < 40);
            if (!acc[0]) fail_now("burst_accept");
        end
        repeat (24) step(1'b0, 8'h00, 1'b1);
        chk("burst_count", 32'(out4.size()), 32'd4);
        for (int i = 0; i < 4 && i < out4.size(); i++)
            chk("burst_order", 32'(out4[i]), 32'(i + 1));

        // Slow-side backpressure for three slots with the stage full
        stalls = 0;
        n = 0;
        while (stalls < 3 && n < 40) begin
            step(1'b1, 8'(8'hB0 + 8'(n)), 1'b0);
            if (s_slot4 === 1'b1 && s_v4 === 1'b1) begin
                chk("bp_hold", 32'(s_data4), 32'hB0);
                stalls++;
            end
            n++;
        end
        if (stalls < 3) fail_now("bp_slots");
        step(1'b0, 8'h00, 1'b0);
        chk("bp_full", 32'(s_rdy4), 32'd0);
`ifdef BSG_PERIODIC_SLOT_BUFFER_STALL_CNT_EN
        chk("bp_stall_cnt", 32'(stall4), 32'd3);
`endif
        repeat (16) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        repeat (300) step(1'($urandom_range(0, 1)), 8'($urandom), 1'(($urandom % 4) != 0));

        // Asynchronous reset while full
        repeat (10) step(1'b1, 8'($urandom), 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("arst_ready4", 32'(rdy4), 32'd0);
        chk("arst_v4", 32'(v4), 32'd0);
        chk("arst_slot4", 32'(slot4), 32'd0);
        chk("arst_data4", 32'(data4), 32'd0);
        chk("arst_ready1", 32'(rdy1), 32'd0);
        chk("arst_v1", 32'(v1), 32'd0);
        chk("arst_slot1", 32'(slot1), 32'd0);
        chk("arst_data1", 32'(data1), 32'd0);
        rel = 1'b0;
        model_reset();
        repeat (2) step(1'b1, 8'h77, 1'b1);
        reset_n_i = 1'b1; rel = 1'b1; cyc = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'h00, 1'b1);
            if (c == 3) begin
                chk("post_rst_slot", 32'(s_slot4), 32'd1);
                chk("post_rst_v", 32'(s_v4), 32'd0);
            end
        end

        // Ratio 1 stream 10..1F
        out1.delete();
        first_out1 = -1;
        e0 = cyc;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            do begin
                step(1'b1, 8'(8'h10 + 8'(i)), 1'b1);
                n++;
            end while (!acc[1] && n < 40);
            if (!acc[1]) fail_now("r1_accept");
        end
        repeat (6) step(1'b0, 8'h00, 1'b1);
        chk("r1_latency", 32'(first_out1 - e0), 32'd2);
        chk("r1_count", 32'(out1.size()), 32'd16);
        for (int i = 0; i < 16 && i < out1.size(); i++)
            chk("r1_order", 32'(out1[i]), 32'(8'h10 + i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
